// File: rtl/mux_sel_sequencer_if.sv
// mux_sel_sequencer_if
//   Bundles the operand handshake and the mux-side outputs of mux_sel_sequencer.
//   clk and rst_n stay plain ports on the module.
//   Signals:
//     in_valid / in_ready   operand pair handshake (source -> sequencer)
//     in_din0 / in_din1     operand pair
//     din0 / din1 / sel     operands and select presented to the mux
//     out_valid             din0/din1/sel are a live sweep step
//     pair_done             final cycle of a pair's sweep
//     busy                  sweep in progress or pairs queued
//     pair_cnt              completed-pair count (SEQ_COUNT_EN builds only)
//   Modports: master = stimulus source / observer, slave = sequencer.
interface mux_sel_sequencer_if #(
    parameter int unsigned DW = 3,
    parameter int unsigned SW = 2
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_din0;
    logic [DW-1:0] in_din1;
    logic [DW-1:0] din0;
    logic [DW-1:0] din1;
    logic [SW-1:0] sel;
    logic          out_valid;
    logic          pair_done;
    logic          busy;
`ifdef SEQ_COUNT_EN
    logic [7:0]    pair_cnt;
`endif

    modport master (
        output in_valid, in_din0, in_din1,
        input  in_ready, din0, din1, sel, out_valid, pair_done, busy
`ifdef SEQ_COUNT_EN
        , input pair_cnt
`endif
    );

    modport slave (
        input  in_valid, in_din0, in_din1,
        output in_ready, din0, din1, sel, out_valid, pair_done, busy
`ifdef SEQ_COUNT_EN
        , output pair_cnt
`endif
    );
endinterface

// File: rtl/mux_sel_sequencer.sv
// mux_sel_sequencer
//   Clocked, back-pressured stimulus source for a 2:1 operand mux. Operand pairs are
//   accepted over a valid/ready handshake into a DEPTH-entry FIFO. Each pair is then played
//   out with sel sweeping 0..2^SW-1, every sel value held for HOLD cycles. Back-to-back
//   pairs follow each other with no gap cycle.
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset (synchronous release expected)
//     bus    mux_sel_sequencer_if.slave (handshake in, din0/din1/sel/out_valid/
//            pair_done/busy out, pair_cnt when enabled)
//   Optional feature: define SEQ_COUNT_EN to add the 8-bit wrapping pair_cnt output.
module mux_sel_sequencer #(
    parameter int unsigned DW    = 3,
    parameter int unsigned SW    = 2,
    parameter int unsigned HOLD  = 10,
    parameter int unsigned DEPTH = 4
) (
    input logic                clk,
    input logic                rst_n,
    mux_sel_sequencer_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [SW-1:0] SelLast  = {SW{1'b1}};
    localparam logic [HW-1:0] HoldLast = HW'(HOLD - 1);

    typedef enum logic [0:0] {StIdle, StStep} state_e;

    // ---------------- operand FIFO ----------------
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] mem1 [DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          full, empty, push, pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // Strictly !full: a pop on the same edge does not open a slot early.
    assign push  = bus.in_valid && !full;

    always_ff @(posedge clk) begin
        if (push) begin
            mem0[wr_ptr_q[AW-1:0]] <= bus.in_din0;
            mem1[wr_ptr_q[AW-1:0]] <= bus.in_din1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // ---------------- sweep FSM ----------------
    state_e        state_q, state_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [DW-1:0] din0_q, din0_d, din1_q, din1_d;
    logic          last_step;

    assign last_step = (state_q == StStep) && (sel_q == SelLast) && (hold_q == HoldLast);

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        hold_d  = hold_q;
        din0_d  = din0_q;
        din1_d  = din1_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop     = 1'b1;
                    din0_d  = mem0[rd_ptr_q[AW-1:0]];
                    din1_d  = mem1[rd_ptr_q[AW-1:0]];
                    sel_d   = '0;
                    hold_d  = '0;
                    state_d = StStep;
                end
            end
            StStep: begin
                if (last_step) begin
                    sel_d  = '0;
                    hold_d = '0;
                    if (!empty) begin
                        // Chain straight into the next pair without an idle cycle.
                        pop    = 1'b1;
                        din0_d = mem0[rd_ptr_q[AW-1:0]];
                        din1_d = mem1[rd_ptr_q[AW-1:0]];
                    end else begin
                        state_d = StIdle;
                    end
                end else if (hold_q == HoldLast) begin
                    hold_d = '0;
                    sel_d  = sel_q + 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sel_q   <= '0;
            hold_q  <= '0;
            din0_q  <= '0;
            din1_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            hold_q  <= hold_d;
            din0_q  <= din0_d;
            din1_q  <= din1_d;
        end
    end

`ifdef SEQ_COUNT_EN
    logic [7:0] pair_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_cnt_q <= '0;
        end else if (last_step) begin
            pair_cnt_q <= pair_cnt_q + 8'd1;
        end
    end

    assign bus.pair_cnt = pair_cnt_q;
`endif

    // sel_q is forced to 0 whenever the FSM idles, so it can drive sel directly.
    assign bus.in_ready  = !full;
    assign bus.din0      = din0_q;
    assign bus.din1      = din1_q;
    assign bus.sel       = sel_q;
    assign bus.out_valid = (state_q == StStep);
    assign bus.pair_done = last_step;
    assign bus.busy      = (state_q == StStep) || !empty;
endmodule
